// File: rtl/memory_part_db_if.sv
// Bus bundle for memory_part_db: fmap/weight write port, fmap and weight
// read ports, bias tap-out and the weight-bank swap handshake.
//
// Handshakes: rd_req and w_req are single-cycle requests. The response is
// registered, and its valid flag is high exactly one cycle after the
// request. Response data holds its last value while no request is made.
// Raise swap_req in ACTIVE to request a bank swap. swap_ack pulses for the
// one cycle in which the swap commits. wr_ready is low from acceptance until
// that commit, and shadow-bank writes offered while it is low are discarded.
interface memory_part_db_if #(
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int TAPS     = 9,
  parameter int HEIGHT   = 8
);
  logic [WIDTH_B-1:0]         write_w;
  logic [HEIGHT_B-1:0]        write_h;
  logic [8*TAPS-1:0]          write;
  logic [TAPS-1:0]            en;
  logic                       wsel;
  logic [WIDTH_B*TAPS-1:0]    readi_w;
  logic [HEIGHT_B*TAPS-1:0]   readi_h;
  logic                       rd_req;
  logic [8*TAPS-1:0]          fmap;
  logic                       fmap_valid;
  logic [2:0]                 step;
  logic                       w_req;
  logic [8*TAPS*HEIGHT-1:0]   weight;
  logic                       weight_valid;
  logic [16*HEIGHT-1:0]       biases;
  logic                       swap_req;
  logic                       swap_ack;
  logic                       wr_ready;
  logic                       err;
  logic [1:0]                 swap_state;

  modport master (
    output write_w, write_h, write, en, wsel, readi_w, readi_h, rd_req,
           step, w_req, swap_req,
    input  fmap, fmap_valid, weight, weight_valid, biases, swap_ack,
           wr_ready, err, swap_state
  );

  modport slave (
    input  write_w, write_h, write, en, wsel, readi_w, readi_h, rd_req,
           step, w_req, swap_req,
    output fmap, fmap_valid, weight, weight_valid, biases, swap_ack,
           wr_ready, err, swap_state
  );
endinterface

// File: rtl/memory_part_db.sv
// Feature-map store plus double-buffered weight/bias banks.
// Multi-lane byte writes go to the fmap or to the shadow weight bank.
// The fmap read is a 9-tap gather. The weight read returns one step slice.
// Biases are tapped combinationally from the active bank. The banks swap
// only after any weight reads in flight have drained.
module memory_part_db #(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 8,
  parameter int WIDTH_B  = 7,
  parameter int HEIGHT_B = 3,
  parameter int TAPS     = 9,
  parameter int STEPS    = 6
) (
  input  logic          clk,
  input  logic          reset,
  memory_part_db_if.slave bus
);
  // Each weight bank holds STEPS*TAPS weight columns plus two bias columns.
  localparam int WCOLS = STEPS * TAPS + 2;
  localparam int FCB   = $clog2(WIDTH);
  localparam int WCB   = $clog2(WCOLS);
  localparam int HB    = $clog2(HEIGHT);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    SWAP   = 2'd2
  } swap_state_t;

  swap_state_t state, state_next;
  logic        active_bank;
  logic        wr_ready;

  logic [7:0] fmem [WIDTH][HEIGHT];
  logic [7:0] wmem [2][WCOLS][HEIGHT];

  logic [WIDTH_B:0]         lane_col [TAPS];
  logic [TAPS-1:0]          lane_wr;
  logic                     wr_err;
  int                       w_base;

  logic [8*TAPS-1:0]        fmap_d, fmap_q;
  logic [8*TAPS*HEIGHT-1:0] weight_d, weight_q;
  logic [16*HEIGHT-1:0]     biases_d;
  logic                     fmap_valid_q, weight_valid_q, err_q;

  assign wr_ready = (state == ACTIVE);

  // Decide for each lane whether to write it. Lanes past the region's last
  // column are dropped. Shadow writes are also dropped while a swap is pending.
  always_comb begin
    wr_err  = 1'b0;
    lane_wr = '0;
    for (int i = 0; i < TAPS; i++) begin
      lane_col[i] = {1'b0, bus.write_w} + (WIDTH_B+1)'(i);
      if (bus.en[TAPS-1-i]) begin
        if (bus.wsel && !wr_ready)
          wr_err = 1'b1;
        else if (int'(lane_col[i]) >= (bus.wsel ? WCOLS : WIDTH))
          wr_err = 1'b1;
        else
          lane_wr[i] = 1'b1;
      end
    end
  end

  // Store the accepted lanes. The memory arrays are never cleared by reset.
  // The active bank is never a write target.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TAPS; i++) begin
      if (lane_wr[i]) begin
        if (bus.wsel)
          wmem[~active_bank][WCB'(lane_col[i])][HB'(bus.write_h)] <= bus.write[8*TAPS-1-8*i -: 8];
        else
          fmem[FCB'(lane_col[i])][HB'(bus.write_h)] <= bus.write[8*TAPS-1-8*i -: 8];
      end
    end
  end

  // Gather the read data from pre-edge memory contents. An out-of-range fmap
  // column reads as zero. An out-of-range step reads as step 0.
  always_comb begin
    fmap_d   = '0;
    weight_d = '0;
    biases_d = '0;
    w_base   = (int'(bus.step) < STEPS) ? int'(bus.step) * TAPS : 0;
    for (int t = 0; t < TAPS; t++) begin
      if (int'(bus.readi_w[WIDTH_B*TAPS-1-WIDTH_B*t -: WIDTH_B]) < WIDTH &&
          int'(bus.readi_h[HEIGHT_B*TAPS-1-HEIGHT_B*t -: HEIGHT_B]) < HEIGHT)
        fmap_d[8*TAPS-1-8*t -: 8] =
          fmem[FCB'(bus.readi_w[WIDTH_B*TAPS-1-WIDTH_B*t -: WIDTH_B])]
              [HB'(bus.readi_h[HEIGHT_B*TAPS-1-HEIGHT_B*t -: HEIGHT_B])];
    end
    for (int r = 0; r < HEIGHT; r++) begin
      for (int k = 0; k < TAPS; k++)
        weight_d[8*TAPS*HEIGHT-1-8*(r*TAPS+k) -: 8] = wmem[active_bank][WCB'(w_base + k)][HB'(r)];
      biases_d[16*HEIGHT-1-16*r -: 16] = {wmem[active_bank][WCB'(WCOLS-2)][HB'(r)],
                                          wmem[active_bank][WCB'(WCOLS-1)][HB'(r)]};
    end
  end

  // Register the read responses. Data holds while no request is made.
  always_ff @(posedge clk) begin
    if (reset) begin
      fmap_q         <= '0;
      weight_q       <= '0;
      fmap_valid_q   <= 1'b0;
      weight_valid_q <= 1'b0;
    end else begin
      fmap_valid_q   <= bus.rd_req;
      weight_valid_q <= bus.w_req;
      if (bus.rd_req) fmap_q   <= fmap_d;
      if (bus.w_req)  weight_q <= weight_d;
    end
  end

  // Swap FSM state register. The bank flips only when SWAP is exited, so a
  // reset during DRAIN abandons the swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ACTIVE;
      active_bank <= 1'b0;
    end else begin
      state <= state_next;
      if (state == SWAP) active_bank <= ~active_bank;
    end
  end

  // Swap FSM next state. swap_req is only looked at in ACTIVE.
  always_comb begin
    state_next = state;
    case (state)
      ACTIVE:  if (bus.swap_req) state_next = bus.w_req ? DRAIN : SWAP;
      DRAIN:   if (!bus.w_req)   state_next = SWAP;
      SWAP:    state_next = ACTIVE;
      default: state_next = ACTIVE;
    endcase
  end

  // The error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (wr_err) err_q <= 1'b1;
  end

  assign bus.fmap         = fmap_q;
  assign bus.fmap_valid   = fmap_valid_q;
  assign bus.weight       = weight_q;
  assign bus.weight_valid = weight_valid_q;
  assign bus.biases       = biases_d;
  assign bus.swap_ack     = (state == SWAP);
  assign bus.wr_ready     = wr_ready;
  assign bus.err          = err_q;
  assign bus.swap_state   = state;
endmodule

// File: tb/tb_memory_part_db.sv
// Bench for memory_part_db. A byte-array model of the fmap and both weight
// banks predicts every read. Directed sequences cover swap, drain and reset.
module tb_memory_part_db;
  logic clk = 1'b0;
  logic reset;
  memory_part_db_if bus ();

  memory_part_db dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  // ---- reference model state ----
  logic [7:0] fm [80][8];
  logic [7:0] wb [2][56][8];
  bit act_m, err_m, rdy_m, ack_m, swap_edge, mem_init;
  logic [71:0]  exp_fmap   = '0;
  logic [575:0] exp_weight = '0;
  logic exp_fv = 1'b0, exp_wv = 1'b0;
  int n_checks = 0, n_fail = 0;

  typedef struct {
    logic [6:0] ww;
    logic [2:0] wh;
    logic [8:0] en;
    logic       wsel;
    logic       exp_err;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [575:0] got, input logic [575:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.write_w = '0; bus.write_h = '0; bus.write = '0; bus.en = '0; bus.wsel = 1'b0;
    bus.readi_w = '0; bus.readi_h = '0; bus.rd_req = 1'b0;
    bus.step = '0; bus.w_req = 1'b0; bus.swap_req = 1'b0;
  endtask

  task automatic set_write(input int ww, input int wh, input logic [8:0] en,
                           input logic ws, input logic [71:0] data);
    bus.write_w = 7'(ww); bus.write_h = 3'(wh); bus.en = en; bus.wsel = ws; bus.write = data;
  endtask

  task automatic set_read(input int col0, input int row);
    for (int t = 0; t < 9; t++) begin
      bus.readi_w[62-7*t -: 7] = 7'(col0 + t);
      bus.readi_h[26-3*t -: 3] = 3'(row);
    end
  endtask

  function automatic logic [71:0] rand_bytes();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [71:0] model_fmap();
    logic [71:0] f = '0;
    for (int t = 0; t < 9; t++) begin
      int col, row;
      col = int'(bus.readi_w[62-7*t -: 7]);
      row = int'(bus.readi_h[26-3*t -: 3]);
      if (col < 80) f[71-8*t -: 8] = fm[col][row];
    end
    return f;
  endfunction

  function automatic logic [575:0] model_weight();
    logic [575:0] w = '0;
    int s;
    s = (int'(bus.step) < 6) ? int'(bus.step) : 0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 9; k++)
        w[575-8*(r*9+k) -: 8] = wb[act_m][s*9+k][r];
    return w;
  endfunction

  function automatic logic [127:0] model_bias();
    logic [127:0] b = '0;
    for (int r = 0; r < 8; r++) b[127-16*r -: 16] = {wb[act_m][54][r], wb[act_m][55][r]};
    return b;
  endfunction

  task automatic model_write();
    for (int i = 0; i < 9; i++) begin
      if (bus.en[8-i]) begin
        int col;
        col = int'(bus.write_w) + i;
        if (bus.wsel && !rdy_m) err_m = 1'b1;
        else if (bus.wsel) begin
          if (col < 56) wb[!act_m][col][bus.write_h] = bus.write[71-8*i -: 8];
          else err_m = 1'b1;
        end else begin
          if (col < 80) fm[col][bus.write_h] = bus.write[71-8*i -: 8];
          else err_m = 1'b1;
        end
      end
    end
  endtask

  // One clock: predict from current inputs, advance, compare everything.
  task automatic step_cycle();
    logic [71:0] f;
    logic [575:0] w;
    if (!reset) begin
      check("wr_ready", bus.wr_ready, rdy_m);
      check("swap_ack", bus.swap_ack, ack_m);
    end
    f = model_fmap();
    w = model_weight();
    model_write();
    if (bus.rd_req) exp_fmap = f;
    if (bus.w_req)  exp_weight = w;
    exp_fv = bus.rd_req;
    exp_wv = bus.w_req;
    if (reset) begin
      exp_fmap = '0; exp_weight = '0; exp_fv = 1'b0; exp_wv = 1'b0;
      act_m = 1'b0; err_m = 1'b0;
    end
    tick();
    if (swap_edge && !reset) act_m = ~act_m;
    swap_edge = 1'b0;
    check("fmap_valid", bus.fmap_valid, exp_fv);
    check("fmap", bus.fmap, exp_fmap);
    check("weight_valid", bus.weight_valid, exp_wv);
    check("weight", bus.weight, exp_weight);
    check("err", bus.err, err_m);
    if (mem_init) check("biases", bus.biases, model_bias());
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    rdy_m = 1'b1; ack_m = 1'b0;
  endtask

  task automatic do_swap();
    bus.swap_req = 1'b1;
    bus.w_req = 1'b0;
    step_cycle();
    bus.swap_req = 1'b0;
    rdy_m = 1'b0; ack_m = 1'b1; swap_edge = 1'b1;
    step_cycle();
    rdy_m = 1'b1; ack_m = 1'b0;
  endtask

  task automatic fill_region(input bit ws, input int limit);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < limit; c += 9) begin
        set_write((c + 9 > limit) ? limit - 9 : c, r, 9'h1FF, ws, rand_bytes());
        step_cycle();
      end
    set_idle();
  endtask

  initial begin
    act_m = 1'b0; err_m = 1'b0; rdy_m = 1'b1; ack_m = 1'b0; swap_edge = 1'b0; mem_init = 1'b0;
    set_idle();
    reset = 1'b1;
    step_cycle();
    step_cycle();
    reset = 1'b0;
    check("reset_wr_ready", bus.wr_ready, 1'b1);
    check("reset_swap_ack", bus.swap_ack, 1'b0);
    check("reset_fmap", bus.fmap, 72'h0);

    // Preload every location so that each read has a defined expectation.
    fill_region(1'b0, 80);
    fill_region(1'b1, 56);
    do_swap();
    fill_region(1'b1, 56);
    mem_init = 1'b1;

    // 9-lane fmap write followed by a read one cycle later.
    set_write(10, 2, 9'h1FF, 1'b0, 72'h010203040506070809);
    step_cycle();
    set_idle();
    set_read(10, 2); bus.rd_req = 1'b1;
    step_cycle();
    check("gather_bytes", bus.fmap, 72'h010203040506070809);
    check("gather_valid", bus.fmap_valid, 1'b1);

    // A read in the same cycle as a write returns the old byte.
    set_idle();
    set_write(5, 0, 9'h100, 1'b0, {8'hAA, 64'h0});
    step_cycle();
    set_write(5, 0, 9'h100, 1'b0, {8'h55, 64'h0});
    set_read(5, 0); bus.rd_req = 1'b1;
    step_cycle();
    check("rw_same_old", bus.fmap[71:64], 8'hAA);
    bus.en = '0;
    step_cycle();
    check("rw_same_new", bus.fmap[71:64], 8'h55);

    // Table of write patterns, each read back across its nine columns.
    vecs[0] = '{7'd0,  3'd0, 9'h1FF, 1'b0, 1'b0};
    vecs[1] = '{7'd20, 3'd7, 9'h155, 1'b0, 1'b0};
    vecs[2] = '{7'd71, 3'd3, 9'h1FF, 1'b0, 1'b0};
    vecs[3] = '{7'd40, 3'd5, 9'h000, 1'b0, 1'b0};
    vecs[4] = '{7'd60, 3'd1, 9'h0AA, 1'b0, 1'b0};
    vecs[5] = '{7'd47, 3'd2, 9'h1FF, 1'b1, 1'b0};
    vecs[6] = '{7'd78, 3'd6, 9'h180, 1'b0, 1'b0};
    vecs[7] = '{7'd50, 3'd4, 9'h1FF, 1'b1, 1'b1};
    vecs[8] = '{7'd75, 3'd4, 9'h1FF, 1'b0, 1'b1};
    for (int v = 0; v < 9; v++) begin
      set_idle();
      set_write(int'(vecs[v].ww), int'(vecs[v].wh), vecs[v].en, vecs[v].wsel, rand_bytes());
      step_cycle();
      set_idle();
      set_read(int'(vecs[v].ww), int'(vecs[v].wh)); bus.rd_req = 1'b1;
      step_cycle();
      check("vec_err", bus.err, vecs[v].exp_err);
    end
    check("edge_col80_zero", bus.fmap[31:24], 8'h00);

    // Shadow fill of step 1 row 0, then a swap with no weight read active.
    do_reset();
    set_write(9, 0, 9'h1FF, 1'b1, 72'h111213141516171819);
    step_cycle();
    set_idle();
    do_swap();
    bus.w_req = 1'b1; bus.step = 3'd1;
    step_cycle();
    check("step1_row0", bus.weight[575:504], 72'h111213141516171819);
    bus.step = 3'd7;
    step_cycle();

    // Swap requested while weight reads continue: drain, then swap.
    set_idle();
    bus.w_req = 1'b1; bus.step = 3'd2; bus.swap_req = 1'b1;
    step_cycle();
    bus.swap_req = 1'b0; rdy_m = 1'b0;
    set_write(18, 3, 9'h1FF, 1'b1, rand_bytes());
    step_cycle();
    check("drain_err", bus.err, 1'b1);
    bus.en = '0;
    step_cycle();
    bus.w_req = 1'b0;
    step_cycle();
    ack_m = 1'b1; swap_edge = 1'b1;
    step_cycle();
    rdy_m = 1'b1; ack_m = 1'b0;
    bus.w_req = 1'b1;
    step_cycle();

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      set_idle();
      if ($urandom_range(0, 39) == 0) begin
        do_swap();
      end else begin
        bus.wsel = 1'($urandom_range(0, 1));
        set_write(bus.wsel ? $urandom_range(0, 55) : $urandom_range(0, 79), $urandom_range(0, 7),
                  9'($urandom), bus.wsel, rand_bytes());
        if ($urandom_range(0, 2) == 0) bus.en = '0;
        set_read($urandom_range(0, 100), $urandom_range(0, 7));
        bus.rd_req = 1'($urandom_range(0, 1));
        bus.w_req  = 1'($urandom_range(0, 1));
        bus.step   = 3'($urandom_range(0, 7));
        step_cycle();
      end
    end

    // Reset during DRAIN abandons the swap and clears the outputs.
    do_reset();
    bus.w_req = 1'b1; bus.swap_req = 1'b1; bus.step = 3'd3;
    step_cycle();
    bus.swap_req = 1'b0; rdy_m = 1'b0;
    step_cycle();
    reset = 1'b1;
    step_cycle();
    reset = 1'b0; rdy_m = 1'b1; ack_m = 1'b0;
    check("rst_drain_weight", bus.weight, 576'h0);
    check("rst_drain_wvalid", bus.weight_valid, 1'b0);
    set_idle();
    for (int n = 0; n < 3; n++) step_cycle();
    bus.w_req = 1'b1; bus.step = 3'd3;
    step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
